sram_port_ctrl: RTL and testbench

Request/response front-end that owns one port of a `DualPort_SRAM` instance.
- Accepts read/write requests over a valid/ready handshake and drives the SRAM port signals.
- Absorbs the SRAM's one-cycle registered read latency into a credit-controlled response FIFO.
- Optionally sweeps the array to zero after reset or on demand, replacing simulation-only memory preload.
- Used by prediction-table and buffer owners inside the renas core.

---
 rtl/renas_package.sv | 16 +
 rtl/sram_rsp_fifo.sv | 60 ++++++
 rtl/sram_port_ctrl.sv | 137 +++++++++++++
 tb/tb_sram_port_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/renas_package.sv
// renas_package: shared types and defaults for the SRAM port controller.
`default_nettype none

package renas_package;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_ctrl_state_e;

  localparam int SRAM_CTRL_DATA_W = 8;
  localparam int SRAM_CTRL_DEPTH  = 16;

endpackage

`default_nettype wire

// File: rtl/sram_rsp_fifo.sv
// +--------------------------------------------------------------------+
// | sram_rsp_fifo: circular response buffer for captured SRAM reads.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module sram_rsp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  // A push into a full buffer is accepted only when a pop frees a slot in the same cycle.
  assign do_push  = push && ((count != FULL) || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/sram_port_ctrl.sv
// +--------------------------------------------------------------------+
// | sram_port_ctrl: valid/ready front-end for one DualPort_SRAM port.  |
// | Optional zero sweep enabled by SRAM_INIT_EN.  Revision: 1.0        |
// +--------------------------------------------------------------------+
`default_nettype none

module sram_port_ctrl
  import renas_package::*;
#(
  parameter int DATA_W    = SRAM_CTRL_DATA_W,
  parameter int DEPTH     = SRAM_CTRL_DEPTH,
  parameter int RSP_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [$clog2(DEPTH)-1:0] req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_rdata,
  input  logic                     clear_req,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [DATA_W-1:0]        sram_wdata,
  output logic                     sram_wen,
  input  logic [DATA_W-1:0]        sram_rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam logic [CW:0] MAX_USED = (CW + 1)'(RSP_DEPTH);

  sram_ctrl_state_e state;
  logic             clear_pending;
  logic [AW-1:0]    cnt;
  logic             inflight;
  logic             req_fire;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      used;

`ifdef SRAM_INIT_EN
  sram_ctrl_state_e state_nxt;
  logic             clear_pending_nxt;
  logic [AW-1:0]    cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      cnt           <= '0;
      clear_pending <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      clear_pending <= clear_pending_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    cnt_nxt           = cnt;
    clear_pending_nxt = clear_pending;
    case (state)
      INIT: begin
        if (cnt == AW'(DEPTH - 1)) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RUN: begin
        // Hold off the sweep until the last read's data has landed in the FIFO.
        if (clear_pending && !inflight) begin
          state_nxt         = INIT;
          clear_pending_nxt = 1'b0;
        end else if (clear_req) begin
          clear_pending_nxt = 1'b1;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign busy = clear_pending || (state == INIT);
`else
  wire unused_clear_req = clear_req;

  assign state         = RUN;
  assign clear_pending = 1'b0;
  assign cnt           = '0;
  assign busy          = 1'b0;
`endif

  // Credit counts both buffered data and the read whose data is still on sram_rdata.
  assign used      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign req_ready = (state == RUN) && !clear_pending && (used < MAX_USED);
  assign req_fire  = req_valid && req_ready;

  always_comb begin
    sram_addr  = req_addr;
    sram_wdata = req_wdata;
    sram_wen   = req_fire && req_we;
    if (state == INIT) begin
      sram_addr  = cnt;
      sram_wdata = '0;
      sram_wen   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= req_fire && !req_we;
  end

  sram_rsp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (sram_rdata),
    .pop       (rsp_ready),
    .pop_data  (rsp_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
// Self-checking bench for sram_port_ctrl with a write-first registered SRAM model.
`default_nettype none

module tb_sram_port_ctrl;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 16;
  localparam int RSP_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic       clear_req, busy;
  logic [3:0] sram_addr;
  logic [7:0] sram_wdata;
  logic       sram_wen;
  logic [7:0] sram_rdata;

  always #5 clk = ~clk;

  sram_port_ctrl #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .clear_req  (clear_req),
    .busy       (busy),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_wen   (sram_wen),
    .sram_rdata (sram_rdata)
  );

  // Write-first SRAM with one-cycle registered read.
  logic [7:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (sram_wen) begin
      sram_mem[sram_addr] <= sram_wdata;
      sram_rdata          <= sram_wdata;
    end else begin
      sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Reference model: expected memory contents plus queue of outstanding reads.
  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mdl [DEPTH];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  logic       s_wen, s_busy, s_rdy;
  logic [3:0] s_addr;
  logic [7:0] s_wdata;
  bit         found;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d,
                      input logic rr, input logic clr, input bit run);
    bit   exp_v;
    exp_t e;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    rsp_ready = rr; clear_req = clr;
    #1;
    s_wen = sram_wen; s_addr = sram_addr; s_wdata = sram_wdata;
    s_busy = busy; s_rdy = req_ready;
    exp_v = (q.size() > 0) && (q[0].cyc <= cyc - 2);
    chk("rsp_valid", rsp_valid, exp_v);
    if (rsp_valid && q.size() > 0) chk("rsp_rdata", rsp_rdata, q[0].data);
    if (run) begin
      chk("req_ready", req_ready, q.size() < RSP_DEPTH);
      chk("busy", busy, 0);
      chk("sram_wen", sram_wen, v && (q.size() < RSP_DEPTH) && we);
      if (v) chk("sram_addr", sram_addr, a);
    end
    if (rsp_valid && rr && q.size() > 0) void'(q.pop_front());
    if (v && req_ready) begin
      if (we) mdl[a] = d;
      else begin
        e.data = mdl[a];
        e.cyc  = cyc;
        q.push_back(e);
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 8'd0, rr, 1'b0, 1'b1);
  endtask

  task automatic reset_release_check();
    rst_n = 1'b1;
`ifdef SRAM_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      chk("sweep_wen", s_wen, 1);
      chk("sweep_addr", s_addr, i);
      chk("sweep_wdata", s_wdata, 0);
      chk("sweep_busy", s_busy, 1);
      chk("sweep_ready", s_rdy, 0);
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
`endif
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clear_req = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
`ifdef SRAM_INIT_EN
    chk("rst_busy", busy, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_sram_wen", sram_wen, 1);
    chk("rst_sram_addr", sram_addr, 0);
`else
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_sram_wen", sram_wen, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    reset_release_check();

    // Preload addr+0x10 into the lower half, random data above.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 1'b1, 4'(i), (i < 8) ? 8'(i + 16) : 8'($urandom), 1'b1, 1'b0, 1'b1);

    // Back-to-back reads with the consumer always ready.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), 8'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("b2b_drained", q.size(), 0);

    // Write then read the same address on the next cycle.
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd3, 8'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Backpressure: only RSP_DEPTH reads may be outstanding.
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'(i + 8), 8'd0, 1'b0, 1'b0, 1'b1);
    chk("bp_accepts", q.size(), RSP_DEPTH);
    idle(8, 1'b1);
    chk("bp_drained", q.size(), 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           8'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    idle(8, 1'b1);
    chk("rand_drained", q.size(), 0);

`ifdef SRAM_INIT_EN
    // Clear coincident with a read: data delivered, then a full sweep.
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd3, 8'd0, 1'b1, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      if (s_wen) found = 1'b1;
      else chk("clr_busy", s_busy, 1);
    end
    chk("clr_sweep_start", found, 1);
    chk("clr_rsp_delivered", q.size(), 0);
    chk("clr_sweep_addr0", s_addr, 0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0);
      chk("clr_sweep_wen", s_wen, 1);
      chk("clr_sweep_addr", s_addr, i);
      chk("clr_sweep_ready", s_rdy, 0);
    end
    for (int i = 0; i < DEPTH; i++) mdl[i] = 8'h00;
    step(1'b1, 1'b0, 4'd3, 8'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("clr_reread_drained", q.size(), 0);

    // Reset in the middle of a sweep with two responses queued.
    step(1'b1, 1'b0, 4'd1, 8'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (s_wen) found = 1'b1;
    end
    chk("rst_sweep_start", found, 1);
    for (int i = 1; i < 7; i++) step(1'b0, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_pre_addr", sram_addr, 7);
    chk("rst_pre_valid", rsp_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_addr", sram_addr, 0);
    chk("rst_mid_busy", busy, 1);
    q.delete();
    @(negedge clk);
    reset_release_check();
`else
    // clear_req has no effect without the sweep.
    step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd3, 8'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b1);
    idle(3, 1'b1);
    chk("clr_ignored_drained", q.size(), 0);

    // Reset with two responses queued.
    step(1'b1, 1'b0, 4'd1, 8'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 4'd2, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", rsp_valid, 0);
    chk("rst_mid_busy", busy, 0);
    q.delete();
    @(negedge clk);
    reset_release_check();
`endif
    // Post-reset read of retained or swept contents.
    step(1'b1, 1'b0, 4'd1, 8'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("final_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
